wb_regfile: RTL
===============

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameters (name, default, meaning): XLEN, 32, data width; PEND_MAX, 3, maximum in-flight writes tracked per register.
REQ-002 SHALL have port: clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports wb_we  input  1, wb_addr  input  5, wb_data  input  XLEN: writeback request from the MEM/WB stage.
REQ-005 SHALL have ports rs1_addr, rs2_addr  input  5: source register addresses.
REQ-006 SHALL have ports rs1_data, rs2_data  output  XLEN: read data, combinational.
REQ-007 SHALL have ports iss_valid  input  1, iss_we  input  1, iss_rd  input  5: issue of an instruction that will write iss_rd.
REQ-008 SHALL have port: iss_ready  output  1  issue may be accepted this cycle.
REQ-009 SHALL have ports rs1_busy, rs2_busy  output  1: source has an outstanding write.
REQ-010 SHALL have port: flush  input  1  discard all in-flight pending writes.
REQ-011 SHALL have port: pend_err  output  1  sticky underflow error flag.

Function
REQ-012 SHALL hold 31 XLEN-bit registers x1..x31; x0 SHALL always read 0 and never be written.
REQ-013 SHALL write wb_data into wb_addr on the rising edge when wb_we=1 and wb_addr!=0; the data SHALL be visible on read ports in the following cycle.
REQ-014 SHALL hold one pending counter per register x1..x31, range 0..PEND_MAX.
REQ-015 SHALL accept an issue when iss_valid=1, iss_we=1, iss_rd!=0 and iss_ready=1; an accepted issue SHALL increment counter[iss_rd].
REQ-016 SHALL drive iss_ready=0 only when iss_we=1, iss_rd!=0 and counter[iss_rd]=PEND_MAX with no same-cycle writeback to iss_rd; otherwise iss_ready=1.
REQ-017 SHALL decrement counter[wb_addr] on each writeback with wb_we=1 and wb_addr!=0.
REQ-018 SHALL leave a counter unchanged when an accepted issue and a writeback target the same register in the same cycle.
REQ-019 SHALL ignore a decrement of a zero counter, leave it at 0, and set pend_err=1 until reset.
REQ-020 SHALL, on flush=1, clear all counters at the next edge; flush SHALL take priority over same-cycle issue and decrement; register writes SHALL still occur.
REQ-021 SHALL drive rsN_busy=1 when rsN_addr!=0 and counter[rsN_addr]!=0, subject to REQ-024; x0 SHALL never be busy.

Reset
REQ-022 SHALL, when reset=1 at a rising edge, clear all registers to 0, all counters to 0 and pend_err to 0; reset SHALL take priority over flush, issue and writeback.
REQ-023 SHALL present, in the first cycle after reset: rs1_data=rs2_data=0, rs1_busy=rs2_busy=0, iss_ready=1, pend_err=0.

Configuration
REQ-024 SHALL support macro WB_REGFILE_BYPASS_EN:
- Defined: when wb_we=1, wb_addr!=0 and wb_addr==rsN_addr, rsN_data SHALL return wb_data in the same cycle, and rsN_busy SHALL be 0 if counter[rsN_addr]==1.
- Undefined: reads SHALL return stored register contents only, and busy SHALL follow REQ-021 unmodified.

Structure
REQ-025 SHALL take XLEN, REG_ADDR_W=5 and NUM_REGS=32 from the shared core package core_pkg.
REQ-026 SHALL use one sub-module, wb_pend_counter, instantiated 31 times; each instance holds one saturating up/down counter with inc, dec and clr inputs and zero, full and underflow outputs.

Verification
REQ-027 SHALL check: reset; wb_we=1, wb_addr=5, wb_data=0xDEADBEEF; next cycle rs1_addr=5 -> rs1_data=0xDEADBEEF.
REQ-028 SHALL check: wb_we=1, wb_addr=0, wb_data=0x12345678 -> rs1_addr=0 reads 0 in the following cycle.
REQ-029 SHALL check: issue rd=7 three times (PEND_MAX=3) -> iss_ready=0 for rd=7; in the same cycle, writeback to 7 plus issue of 7 -> issue accepted and counter stays 3.
REQ-030 SHALL check: with BYPASS_EN, counter[3]=1, same cycle wb_we=1, wb_addr=3, wb_data=0xA5A5A5A5, rs2_addr=3 -> rs2_data=0xA5A5A5A5 and rs2_busy=0; without BYPASS_EN -> old data and rs2_busy=1.
REQ-031 SHALL check: counters for x4=2 and x9=1, then flush=1 -> next cycle rs1_busy=rs2_busy=0 with rs1_addr=4, rs2_addr=9; a later writeback to 4 -> pend_err=1.
REQ-032 SHALL check: reset asserted while three writes are pending -> all busy outputs 0, all registers read 0, and iss_ready=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core constants for the register file and its pending-write tracking.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // Bits needed to hold a count in the range 0..max.
  function automatic int pend_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/wb_pend_counter.sv
// Saturating up/down counter of in-flight writes for one architectural register.
module wb_pend_counter
  import core_pkg::*;
#(
  parameter int MAX = 3,
  parameter int W   = pend_width(MAX)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic         zero,
  output logic         full,
  output logic         underflow,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  assign count = count_reg;
  assign zero  = (count_reg == '0);
  assign full  = (count_reg == W'(MAX));
  // A matched inc/dec pair nets to zero, so only a lone decrement can underflow.
  assign underflow = dec && !inc && !clr && zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && !dec && !full) begin
      count_reg <= count_reg + W'(1);
    end else if (dec && !inc && !zero) begin
      count_reg <= count_reg - W'(1);
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Integer register file with per-register pending-write scoreboard.
// Optional same-cycle writeback bypass on the read ports: WB_REGFILE_BYPASS_EN.
module wb_regfile
  import core_pkg::*;
#(
  parameter int XLEN     = core_pkg::XLEN,
  parameter int PEND_MAX = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  input  logic                  iss_valid,
  input  logic                  iss_we,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  output logic                  iss_ready,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  flush,
  output logic                  pend_err
);

  localparam int CW = pend_width(PEND_MAX);

  logic [XLEN-1:0]     regs [1:NUM_REGS-1];
  logic [NUM_REGS-1:0] zero_vec;
  logic [NUM_REGS-1:0] full_vec;
  logic [NUM_REGS-1:0] under_vec;
  logic [CW-1:0]       cnt [NUM_REGS];
  logic                wb_hit;
  logic                iss_acc;
  logic                pend_err_reg;

  assign wb_hit    = wb_we && (wb_addr != '0);
  // A writeback to the same register frees a slot, so a full counter can still accept.
  assign iss_ready = !(iss_we && (iss_rd != '0) && full_vec[iss_rd] &&
                       !(wb_hit && (wb_addr == iss_rd)));
  assign iss_acc   = iss_valid && iss_we && (iss_rd != '0) && iss_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_hit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign zero_vec[0]  = 1'b1;
  assign full_vec[0]  = 1'b0;
  assign under_vec[0] = 1'b0;
  assign cnt[0]       = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_pend
      wb_pend_counter #(
        .MAX (PEND_MAX),
        .W   (CW)
      ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc       (iss_acc && (iss_rd == REG_ADDR_W'(gi))),
        .dec       (wb_hit && (wb_addr == REG_ADDR_W'(gi))),
        .clr       (flush),
        .zero      (zero_vec[gi]),
        .full      (full_vec[gi]),
        .underflow (under_vec[gi]),
        .count     (cnt[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_err_reg <= 1'b0;
    end else if (|under_vec) begin
      pend_err_reg <= 1'b1;
    end
  end

  assign pend_err = pend_err_reg;

  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
    rs1_busy = !zero_vec[rs1_addr];
    rs2_busy = !zero_vec[rs2_addr];
`ifdef WB_REGFILE_BYPASS_EN
    // The last outstanding write is landing now, so its data is already final.
    if (wb_hit && (wb_addr == rs1_addr)) begin
      rs1_data = wb_data;
      if (cnt[rs1_addr] == CW'(1)) rs1_busy = 1'b0;
    end
    if (wb_hit && (wb_addr == rs2_addr)) begin
      rs2_data = wb_data;
      if (cnt[rs2_addr] == CW'(1)) rs2_busy = 1'b0;
    end
`endif
  end

endmodule
